hazard_scheduler: RTL and testbench

- Central pipeline scheduler for the 5-stage CPU.
- Drives the EX-stage forwarding selects (PassSrcA/PassSrcB) and the D-stage branch-compare forwarding selects.
- Raises stall/bubble for load-use and branch hazards.
- Sequences the multi-cycle HI/LO multiply/divide unit with a busy FSM, stalling D-stage md instructions while it runs.

---
 rtl/hazard_scheduler.sv | 170 +++++++++++++++++
 tb/tb_hazard_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Purpose : pipeline hazard scheduler: EX/D forwarding selects, load-use/branch stalls, HI/LO md-unit sequencer.
// Latency : selects and stall are combinational (0 cycles); md_busy rises the cycle after the start edge, md_done pulses one cycle after the last busy cycle.
// Backpr. : stall freezes PC and F/D and bubbles D/E (E_flush); D-stage md instructions are held while the md unit is occupied.
//
// Ports   : D_* describe the instruction in decode; E_*/M_*/W_* describe the write side of later stages.
//           PassSrcA/B select EX operands and D_PassA/B select branch-compare operands (00 RD1, 01 M pass, 10 W WRD).
//           md_busy/md_done report the multiply/divide unit.
// Option  : define HAZARD_STATS_EN to add the 32-bit stall_cnt / fwd_cnt performance counters.
module hazard_scheduler #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_use_rs_D,
    input  logic       D_use_rt_D,
    input  logic       D_use_rs_E,
    input  logic       D_use_rt_E,
    input  logic       D_is_md,
    input  logic [4:0] E_rs,
    input  logic [4:0] E_rt,
    input  logic [4:0] E_WRA,
    input  logic       E_wr,
    input  logic       E_is_load,
    input  logic [1:0] E_md_op,
    input  logic [4:0] M_WRA,
    input  logic       M_wr,
    input  logic       M_is_load,
    input  logic [4:0] W_WRA,
    input  logic       W_wr,
    output logic       stall,
    output logic       E_flush,
    output logic [1:0] PassSrcA,
    output logic [1:0] PassSrcB,
    output logic [1:0] D_PassA,
    output logic [1:0] D_PassB,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] fwd_cnt
`endif
);

    localparam logic [CNT_W-1:0] L_MULT_LAST = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] L_DIV_LAST  = CNT_W'(DIV_CYC - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t        r_state;
    md_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_md_done;
    logic             w_md_done_nxt;

    // A stage "matches" r when it writes the GPR file at r; $0 is never a real destination.
    function automatic logic f_match(input logic wr, input logic [4:0] wra, input logic [4:0] r);
        return wr && (wra == r) && (r != 5'd0);
    endfunction

    // M wins over W because it holds the younger value; a load in M has no data yet, so it
    // is skipped here and the stall terms cover the cases where that matters.
    function automatic logic [1:0] f_sel(input logic m_hit, input logic m_load, input logic w_hit);
        if (m_hit && !m_load) return 2'b01;
        if (w_hit)            return 2'b10;
        return 2'b00;
    endfunction

    logic w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt;
    logic w_stall_load, w_stall_br_e, w_stall_br_m, w_stall_md;
    logic w_stall;

    assign w_e_hit_rs = f_match(E_wr, E_WRA, D_rs);
    assign w_e_hit_rt = f_match(E_wr, E_WRA, D_rt);
    assign w_m_hit_rs = f_match(M_wr, M_WRA, D_rs);
    assign w_m_hit_rt = f_match(M_wr, M_WRA, D_rt);

    // Load in E: data arrives too late for any consumer of the D instruction.
    assign w_stall_load = E_is_load && ((w_e_hit_rs && (D_use_rs_D || D_use_rs_E)) ||
                                        (w_e_hit_rt && (D_use_rt_D || D_use_rt_E)));
    // Branch compare in D cannot see E's ALU result (no E->D path).
    assign w_stall_br_e = (w_e_hit_rs && D_use_rs_D) || (w_e_hit_rt && D_use_rt_D);
    // Branch compare in D behind a load still in M.
    assign w_stall_br_m = M_is_load && ((w_m_hit_rs && D_use_rs_D) || (w_m_hit_rt && D_use_rt_D));
    // md instruction in D while the unit is running or about to be started by E.
    assign w_stall_md   = D_is_md && ((r_state == S_BUSY) || (E_md_op != 2'b00));

    assign w_stall = w_stall_load || w_stall_br_e || w_stall_br_m || w_stall_md;

    assign stall    = reset ? 1'b0  : w_stall;
    assign E_flush  = reset ? 1'b0  : w_stall;
    assign PassSrcA = reset ? 2'b00 : f_sel(f_match(M_wr, M_WRA, E_rs), M_is_load, f_match(W_wr, W_WRA, E_rs));
    assign PassSrcB = reset ? 2'b00 : f_sel(f_match(M_wr, M_WRA, E_rt), M_is_load, f_match(W_wr, W_WRA, E_rt));
    assign D_PassA  = reset ? 2'b00 : f_sel(w_m_hit_rs, M_is_load, f_match(W_wr, W_WRA, D_rs));
    assign D_PassB  = reset ? 2'b00 : f_sel(w_m_hit_rt, M_is_load, f_match(W_wr, W_WRA, D_rt));

    assign md_busy = (r_state == S_BUSY);
    assign md_done = r_md_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_md_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_md_done <= w_md_done_nxt;
        end
    end

    // Start is taken regardless of stall: the md op has already left D and owns the unit.
    // New ops seen while busy are ignored; the D-stage interlock keeps them from arriving.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_md_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (E_md_op == 2'b01) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = L_MULT_LAST;
                end else if (E_md_op == 2'b10) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = L_DIV_LAST;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = S_IDLE;
                    w_md_done_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((PassSrcA != 2'b00) || (PassSrcB != 2'b00))
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Purpose : directed + random check of hazard_scheduler against a cycle-count reference model.
// Latency : outputs sampled mid-cycle; model advanced on each rising edge.
// Backpr. : none; the bench drives every input every cycle.
module tb_hazard_scheduler;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_rs, E_rt, E_WRA, M_WRA, W_WRA;
    logic       D_use_rs_D, D_use_rt_D, D_use_rs_E, D_use_rt_E, D_is_md;
    logic       E_wr, E_is_load, M_wr, M_is_load, W_wr;
    logic [1:0] E_md_op;
    logic       stall, E_flush, md_busy, md_done;
    logic [1:0] PassSrcA, PassSrcB, D_PassA, D_PassB;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
    logic [31:0] exp_stall_cnt = 32'd0;
    logic [31:0] exp_fwd_cnt   = 32'd0;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    // Reference md model: number of busy cycles still to be shown, plus the done pulse.
    int   md_rem  = 0;
    logic md_done_exp = 1'b0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt),
        .D_use_rs_D(D_use_rs_D), .D_use_rt_D(D_use_rt_D),
        .D_use_rs_E(D_use_rs_E), .D_use_rt_E(D_use_rt_E),
        .D_is_md(D_is_md),
        .E_rs(E_rs), .E_rt(E_rt), .E_WRA(E_WRA), .E_wr(E_wr),
        .E_is_load(E_is_load), .E_md_op(E_md_op),
        .M_WRA(M_WRA), .M_wr(M_wr), .M_is_load(M_is_load),
        .W_WRA(W_WRA), .W_wr(W_wr),
        .stall(stall), .E_flush(E_flush),
        .PassSrcA(PassSrcA), .PassSrcB(PassSrcB),
        .D_PassA(D_PassA), .D_PassB(D_PassB),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        D_rs = 0; D_rt = 0; E_rs = 0; E_rt = 0; E_WRA = 0; M_WRA = 0; W_WRA = 0;
        D_use_rs_D = 0; D_use_rt_D = 0; D_use_rs_E = 0; D_use_rt_E = 0; D_is_md = 0;
        E_wr = 0; E_is_load = 0; M_wr = 0; M_is_load = 0; W_wr = 0; E_md_op = 2'b00;
    endtask

    // Where the operand for register r should come from (youngest ready producer).
    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (reset || r == 5'd0) return 2'b00;
        if (M_wr && M_WRA == r && !M_is_load) return 2'b01;
        if (W_wr && W_WRA == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic m_stall();
        logic e_rs, e_rt, m_rs, m_rt;
        if (reset) return 1'b0;
        e_rs = E_wr && E_WRA == D_rs && D_rs != 0;
        e_rt = E_wr && E_WRA == D_rt && D_rt != 0;
        m_rs = M_wr && M_WRA == D_rs && D_rs != 0;
        m_rt = M_wr && M_WRA == D_rt && D_rt != 0;
        return (E_is_load && ((e_rs && (D_use_rs_D || D_use_rs_E)) || (e_rt && (D_use_rt_D || D_use_rt_E))))
            || (e_rs && D_use_rs_D) || (e_rt && D_use_rt_D)
            || (M_is_load && ((m_rs && D_use_rs_D) || (m_rt && D_use_rt_D)))
            || (D_is_md && (md_rem > 0 || E_md_op != 2'b00));
    endfunction

    // Check every output against the model mid-cycle, then advance the model across the edge.
    task automatic cycle(input string tag);
        logic       s;
        logic [1:0] fa, fb;
        @(negedge clk);
        s  = m_stall();
        fa = m_fwd(E_rs);
        fb = m_fwd(E_rt);
        chk({tag, ".stall"},    32'(stall),    32'(s));
        chk({tag, ".flush"},    32'(E_flush),  32'(s));
        chk({tag, ".PassSrcA"}, 32'(PassSrcA), 32'(fa));
        chk({tag, ".PassSrcB"}, 32'(PassSrcB), 32'(fb));
        chk({tag, ".D_PassA"},  32'(D_PassA),  32'(m_fwd(D_rs)));
        chk({tag, ".D_PassB"},  32'(D_PassB),  32'(m_fwd(D_rt)));
        chk({tag, ".md_busy"},  32'(md_busy),  32'(md_rem > 0));
        chk({tag, ".md_done"},  32'(md_done),  32'(md_done_exp));
`ifdef HAZARD_STATS_EN
        chk({tag, ".stall_cnt"}, stall_cnt, exp_stall_cnt);
        chk({tag, ".fwd_cnt"},   fwd_cnt,   exp_fwd_cnt);
`endif
        @(posedge clk);
        if (reset) begin
            md_rem      = 0;
            md_done_exp = 1'b0;
`ifdef HAZARD_STATS_EN
            exp_stall_cnt = 0;
            exp_fwd_cnt   = 0;
`endif
        end else begin
            md_done_exp = (md_rem == 1);
            if (md_rem > 0)             md_rem--;
            else if (E_md_op == 2'b01)  md_rem = MULT_CYC;
            else if (E_md_op == 2'b10)  md_rem = DIV_CYC;
`ifdef HAZARD_STATS_EN
            if (s) exp_stall_cnt++;
            if (fa != 2'b00 || fb != 2'b00) exp_fwd_cnt++;
`endif
        end
        #1;
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        int done_seen;
        int r;

        // ---- reset: outputs gated even with hazardous inputs ----
        clr();
        reset = 1'b1;
        @(posedge clk); #1;
        M_wr = 1; M_WRA = 8; E_rs = 8;
        E_wr = 1; E_WRA = 3; D_rs = 3; D_use_rs_D = 1; E_md_op = 2'b01;
        #1;
        chk("rst.PassSrcA", 32'(PassSrcA), 0);
        chk("rst.stall",    32'(stall),    0);
        chk("rst.md_busy",  32'(md_busy),  0);
        cycle("rst");
        reset = 1'b0;
        clr();

        // ---- forwarding priority ----
        M_wr = 1; M_WRA = 8; W_wr = 1; W_WRA = 8; E_rs = 8;
        #1 chk("fp.m_first", 32'(PassSrcA), 1);
        cycle("fp1");
        M_wr = 0;
        #1 chk("fp.w_only", 32'(PassSrcA), 2);
        cycle("fp2");
        M_wr = 1; M_WRA = 0; W_WRA = 0; E_rs = 0;
        #1 chk("fp.zero_reg", 32'(PassSrcA), 0);
        cycle("fp3");

        // ---- load-use ----
        clr(); E_is_load = 1; E_wr = 1; E_WRA = 9; D_rt = 9; D_use_rt_E = 1;
        #1 chk("lu.stall", 32'(stall), 1);
        chk("lu.flush", 32'(E_flush), 1);
        cycle("lu1");
        clr(); M_is_load = 1; M_wr = 1; M_WRA = 9; D_rt = 9; D_use_rt_E = 1;
        #1 chk("lu.release", 32'(stall), 0);
        cycle("lu2");
        clr(); W_wr = 1; W_WRA = 9; E_rt = 9;
        #1 chk("lu.fwdB", 32'(PassSrcB), 2);
        cycle("lu3");

        // ---- branch hazard ----
        clr(); E_wr = 1; E_WRA = 5; D_rs = 5; D_use_rs_D = 1;
        #1 chk("br.stall", 32'(stall), 1);
        cycle("br1");
        clr(); M_wr = 1; M_WRA = 5; D_rs = 5; D_use_rs_D = 1;
        #1 chk("br.release", 32'(stall), 0);
        chk("br.D_PassA", 32'(D_PassA), 1);
        cycle("br2");

        // ---- mult sequencing ----
        clr(); D_is_md = 1; E_md_op = 2'b01;
        #1 chk("mul.stall0", 32'(stall), 1);
        cycle("mul");
        E_md_op = 2'b00;
        busy_cnt = 0; done_at = -1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            if (md_busy === 1'b1) busy_cnt++;
            if (md_done === 1'b1) done_at = i;
            cycle("mul");
        end
        chk("mul.busy_cycles", 32'(busy_cnt), MULT_CYC);
        chk("mul.done_cycle",  32'(done_at),  MULT_CYC + 1);

        // ---- div aborted by reset, then a full div ----
        clr(); E_md_op = 2'b10;
        cycle("div");
        E_md_op = 2'b00;
        for (int i = 1; i <= 3; i++) cycle("div");
        reset = 1'b1;
        cycle("div.rst");
        reset = 1'b0;
        #1 chk("div.abort_busy", 32'(md_busy), 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (md_done !== 1'b0) done_seen++;
            cycle("div.idle");
        end
        chk("div.no_done", 32'(done_seen), 0);
        E_md_op = 2'b10;
        cycle("div2");
        E_md_op = 2'b00;
        busy_cnt = 0;
        for (int i = 0; i < 13; i++) begin
            #1;
            if (md_busy === 1'b1) busy_cnt++;
            cycle("div2");
        end
        chk("div.busy_cycles", 32'(busy_cnt), DIV_CYC);

        // ---- randomized traffic over a small register set to force collisions ----
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            E_rs       = 5'($urandom_range(0, 3));
            E_rt       = 5'($urandom_range(0, 3));
            E_WRA      = 5'($urandom_range(0, 3));
            M_WRA      = 5'($urandom_range(0, 3));
            W_WRA      = 5'($urandom_range(0, 3));
            D_use_rs_D = 1'($urandom_range(0, 1));
            D_use_rt_D = 1'($urandom_range(0, 1));
            D_use_rs_E = 1'($urandom_range(0, 1));
            D_use_rt_E = 1'($urandom_range(0, 1));
            D_is_md    = 1'($urandom_range(0, 1));
            E_wr       = 1'($urandom_range(0, 1));
            E_is_load  = 1'($urandom_range(0, 1));
            M_wr       = 1'($urandom_range(0, 1));
            M_is_load  = 1'($urandom_range(0, 1));
            W_wr       = 1'($urandom_range(0, 1));
            r          = int'($urandom_range(0, 15));
            E_md_op    = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : 2'b00;
            cycle("rnd");
        end
        reset = 1'b0;

`ifdef HAZARD_STATS_EN
        // ---- counters: one load-use stall, then three forwarded instructions ----
        clr(); reset = 1'b1;
        cycle("st.rst");
        reset = 1'b0;
        E_is_load = 1; E_wr = 1; E_WRA = 9; D_rt = 9; D_use_rt_E = 1;
        cycle("st.lu");
        for (int i = 0; i < 3; i++) begin
            clr(); M_wr = 1; M_WRA = 4; E_rs = 4;
            cycle("st.fwd");
        end
        clr();
        #1;
        chk("stats.stall_cnt", stall_cnt, 1);
        chk("stats.fwd_cnt",   fwd_cnt,   3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
